// File: rtl/axi_rd_arbiter_pkg.sv
// Shared constants and types for the read-side AXI arbiter.
// Holds AXI IDs, icache read-type encodings and the AR payload record.
package axi_rd_arbiter_pkg;

  localparam logic [3:0] IC_ID          = 4'd0;
  localparam logic [3:0] D_ID           = 4'd1;

  localparam logic [2:0] RD_LINE        = 3'b100;
  localparam logic [2:0] RD_WORD        = 3'b010;

  localparam logic [1:0] AXI_BURST_INCR = 2'b01;
  localparam logic [7:0] LINE_ARLEN     = 8'd3;
  localparam logic [2:0] AXI_SIZE_WORD  = 3'b010;

  typedef enum logic {
    AR_IDLE,
    AR_SEND
  } ar_state_t;

  typedef struct packed {
    logic [3:0]  id;
    logic [31:0] addr;
    logic [7:0]  len;
    logic [2:0]  size;
  } ar_payload_t;

endpackage

// File: rtl/axi_ar_slot.sv
// Single-entry AR holding register: captures a payload on load and keeps
// it stable with valid high until the AXI slave takes it.
module axi_ar_slot
  import axi_rd_arbiter_pkg::*;
(
  input  logic        clk,
  input  logic        resetn,
  input  logic        load,
  input  ar_payload_t ld_payload,
  input  logic        ready,
  output logic        valid,
  output ar_payload_t payload
);

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      valid   <= 1'b0;
      payload <= '0;
    end else if (load && !valid) begin
      valid   <= 1'b1;
      payload <= ld_payload;
    end else if (valid && ready) begin
      valid   <= 1'b0;
    end
  end

endmodule

// File: rtl/axi_rd_arbiter.sv
// Read-side AXI master: arbitrates icache refills and data reads onto one
// AR slot (data has priority) and routes R beats back by rid.
module axi_rd_arbiter #(
  parameter logic [3:0] IC_ID = 4'd0,
  parameter logic [3:0] D_ID  = 4'd1
) (
  input  logic        clk,
  input  logic        resetn,

  input  logic        ic_rd_req,
  input  logic [2:0]  ic_rd_type,
  input  logic [31:0] ic_rd_addr,
  output logic        ic_rd_rdy,
  output logic        ic_ret_valid,
  output logic        ic_ret_last,
  output logic [31:0] ic_ret_data,

  input  logic        d_req,
  input  logic [1:0]  d_size,
  input  logic [31:0] d_addr,
  input  logic        d_rd_block,
  output logic        d_addr_ok,
  output logic        d_data_ok,
  output logic [31:0] d_rdata,

  output logic [3:0]  arid,
  output logic [31:0] araddr,
  output logic [7:0]  arlen,
  output logic [2:0]  arsize,
  output logic [1:0]  arburst,
  output logic        arvalid,
  input  logic        arready,

  input  logic [3:0]  rid,
  input  logic [31:0] rdata,
  input  logic [1:0]  rresp,
  input  logic        rlast,
  input  logic        rvalid,
  output logic        rready
);

  import axi_rd_arbiter_pkg::*;

  ar_state_t   state;
  logic        ic_out;
  logic        d_out;
  logic        d_elig;
  logic        ic_elig;
  logic        accept_d;
  logic        accept_ic;
  logic        r_fin;
  logic        unused_rresp;
  ar_payload_t ld_payload;
  ar_payload_t ar_q;

  assign d_elig    = d_req && !d_rd_block && !d_out;
  assign ic_elig   = ic_rd_req && !ic_out;
  assign accept_d  = (state == AR_IDLE) && d_elig;
  assign accept_ic = (state == AR_IDLE) && ic_elig && !d_elig;

  assign d_addr_ok = accept_d;
  assign ic_rd_rdy = accept_ic;

  always_comb begin
    ld_payload = '0;
    if (accept_d) begin
      ld_payload.id   = D_ID;
      ld_payload.addr = d_addr;
      ld_payload.len  = '0;
      ld_payload.size = {1'b0, d_size};
    end else if (ic_rd_type == RD_LINE) begin
      ld_payload.id   = IC_ID;
      ld_payload.addr = {ic_rd_addr[31:4], 4'b0000};
      ld_payload.len  = LINE_ARLEN;
      ld_payload.size = AXI_SIZE_WORD;
    end else begin
      ld_payload.id   = IC_ID;
      ld_payload.addr = ic_rd_addr;
      ld_payload.len  = '0;
      ld_payload.size = AXI_SIZE_WORD;
    end
  end

  // No acceptance on the handshake cycle: the slot is still full there.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state <= AR_IDLE;
    end else begin
      case (state)
        AR_IDLE: if (accept_d || accept_ic) state <= AR_SEND;
        AR_SEND: if (arvalid && arready)    state <= AR_IDLE;
        default:                            state <= AR_IDLE;
      endcase
    end
  end

  axi_ar_slot u_ar_slot (
    .clk        (clk),
    .resetn     (resetn),
    .load       (accept_d || accept_ic),
    .ld_payload (ld_payload),
    .ready      (arready),
    .valid      (arvalid),
    .payload    (ar_q)
  );

  assign arid    = ar_q.id;
  assign araddr  = ar_q.addr;
  assign arlen   = ar_q.len;
  assign arsize  = ar_q.size;
  assign arburst = AXI_BURST_INCR;

  assign rready       = 1'b1;
  assign r_fin        = rvalid && rready && rlast;
  assign unused_rresp = ^rresp;

  // Set has priority over clear for each outstanding flag.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      ic_out <= 1'b0;
      d_out  <= 1'b0;
    end else begin
      if (accept_ic)                 ic_out <= 1'b1;
      else if (r_fin && rid == IC_ID) ic_out <= 1'b0;
      if (accept_d)                  d_out  <= 1'b1;
      else if (r_fin && rid == D_ID) d_out  <= 1'b0;
    end
  end

  assign ic_ret_valid = rvalid && (rid == IC_ID);
  assign ic_ret_last  = rlast;
  assign ic_ret_data  = rdata;

  assign d_data_ok = rvalid && rlast && (rid == D_ID);
  assign d_rdata   = rdata;

endmodule

// File: tb/tb_axi_rd_arbiter.sv
// Self-checking bench for axi_rd_arbiter: transaction-level model checked
// every cycle, plus directed scenarios with hand-computed expectations.
module tb_axi_rd_arbiter;

  logic        clk = 1'b0;
  logic        resetn = 1'b0;
  logic        ic_rd_req = 1'b0;
  logic [2:0]  ic_rd_type = 3'b100;
  logic [31:0] ic_rd_addr = '0;
  logic        ic_rd_rdy, ic_ret_valid, ic_ret_last;
  logic [31:0] ic_ret_data;
  logic        d_req = 1'b0;
  logic [1:0]  d_size = '0;
  logic [31:0] d_addr = '0;
  logic        d_rd_block = 1'b0;
  logic        d_addr_ok, d_data_ok;
  logic [31:0] d_rdata;
  logic [3:0]  arid;
  logic [31:0] araddr;
  logic [7:0]  arlen;
  logic [2:0]  arsize;
  logic [1:0]  arburst;
  logic        arvalid;
  logic        arready = 1'b0;
  logic [3:0]  rid = '0;
  logic [31:0] rdata = '0;
  logic [1:0]  rresp = 2'b11;
  logic        rlast = 1'b0;
  logic        rvalid = 1'b0;
  logic        rready;

  int checks = 0;
  int errors = 0;
  int n_icv = 0, n_icl = 0, n_dok = 0;

  always #5 clk = ~clk;

  axi_rd_arbiter #(.IC_ID(4'd0), .D_ID(4'd1)) dut (
    .clk(clk), .resetn(resetn),
    .ic_rd_req(ic_rd_req), .ic_rd_type(ic_rd_type), .ic_rd_addr(ic_rd_addr),
    .ic_rd_rdy(ic_rd_rdy), .ic_ret_valid(ic_ret_valid), .ic_ret_last(ic_ret_last),
    .ic_ret_data(ic_ret_data),
    .d_req(d_req), .d_size(d_size), .d_addr(d_addr), .d_rd_block(d_rd_block),
    .d_addr_ok(d_addr_ok), .d_data_ok(d_data_ok), .d_rdata(d_rdata),
    .arid(arid), .araddr(araddr), .arlen(arlen), .arsize(arsize), .arburst(arburst),
    .arvalid(arvalid), .arready(arready),
    .rid(rid), .rdata(rdata), .rresp(rresp), .rlast(rlast), .rvalid(rvalid),
    .rready(rready)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  // Transaction-level model: one pending AR record and one busy bit per ID.
  logic        m_pend = 1'b0, m_ic_busy = 1'b0, m_d_busy = 1'b0;
  logic [3:0]  m_id;
  logic [31:0] m_addr;
  logic [7:0]  m_len;
  logic [2:0]  m_size;
  logic        e_d_ok, e_ic_rdy;

  assign e_d_ok   = !m_pend && d_req && !d_rd_block && !m_d_busy;
  assign e_ic_rdy = !m_pend && ic_rd_req && !m_ic_busy &&
                    !(d_req && !d_rd_block && !m_d_busy);

  always @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      m_pend    <= 1'b0;
      m_ic_busy <= 1'b0;
      m_d_busy  <= 1'b0;
    end else begin
      if (rvalid && rlast && rid == 4'd0) m_ic_busy <= 1'b0;
      if (rvalid && rlast && rid == 4'd1) m_d_busy  <= 1'b0;
      if (m_pend && arready) begin
        m_pend <= 1'b0;
      end else if (e_d_ok) begin
        m_pend <= 1'b1; m_d_busy <= 1'b1;
        m_id <= 4'd1; m_addr <= d_addr; m_len <= 8'd0; m_size <= {1'b0, d_size};
      end else if (e_ic_rdy) begin
        m_pend <= 1'b1; m_ic_busy <= 1'b1; m_id <= 4'd0; m_size <= 3'd2;
        if (ic_rd_type == 3'b100) begin
          m_addr <= ic_rd_addr & 32'hFFFF_FFF0; m_len <= 8'd3;
        end else begin
          m_addr <= ic_rd_addr; m_len <= 8'd0;
        end
      end
    end
  end

  always @(negedge clk) begin
    chk("arvalid", arvalid, m_pend);
    if (m_pend) begin
      chk("arid", arid, m_id);
      chk("araddr", araddr, m_addr);
      chk("arlen", arlen, m_len);
      chk("arsize", arsize, m_size);
    end
    chk("arburst", arburst, 2'b01);
    chk("d_addr_ok", d_addr_ok, e_d_ok);
    chk("ic_rd_rdy", ic_rd_rdy, e_ic_rdy);
    chk("rready", rready, 1'b1);
    chk("ic_ret_valid", ic_ret_valid, rvalid && rid == 4'd0);
    chk("ic_ret_last", ic_ret_last, rlast);
    chk("ic_ret_data", ic_ret_data, rdata);
    chk("d_data_ok", d_data_ok, rvalid && rlast && rid == 4'd1);
    chk("d_rdata", d_rdata, rdata);
    if (ic_ret_valid) n_icv++;
    if (ic_ret_valid && ic_ret_last) n_icl++;
    if (d_data_ok) n_dok++;
  end

  task automatic step();
    @(posedge clk); #1;
  endtask

  task automatic wait_acc(input bit is_d, input string nm);
    bit ok = 1'b0;
    for (int i = 0; i < 20 && !ok; i++) begin
      @(negedge clk);
      ok = is_d ? d_addr_ok : ic_rd_rdy;
    end
    chk(nm, ok, 1'b1);
    step();
    if (is_d) d_req = 1'b0; else ic_rd_req = 1'b0;
  endtask

  task automatic ar_accept(input string nm, input logic [3:0] id, input logic [31:0] a,
                           input logic [7:0] l, input logic [2:0] s, input int unsigned hold);
    bit seen = 1'b0;
    for (int i = 0; i < 20 && !seen; i++) begin
      @(negedge clk);
      seen = arvalid;
    end
    chk({nm, "_seen"}, seen, 1'b1);
    chk({nm, "_arid"}, arid, id);
    chk({nm, "_araddr"}, araddr, a);
    chk({nm, "_arlen"}, arlen, l);
    chk({nm, "_arsize"}, arsize, s);
    for (int unsigned k = 0; k < hold; k++) begin
      @(negedge clk);
      chk({nm, "_hold_arvalid"}, arvalid, 1'b1);
      chk({nm, "_hold_araddr"}, araddr, a);
      chk({nm, "_hold_arid"}, arid, id);
      chk({nm, "_hold_arlen"}, arlen, l);
      chk({nm, "_hold_no_addr_ok"}, d_addr_ok, 1'b0);
      chk({nm, "_hold_no_rdy"}, ic_rd_rdy, 1'b0);
    end
    step();
    arready = 1'b1;
    step();
    arready = 1'b0;
  endtask

  task automatic beat(input logic [3:0] id, input logic [31:0] data, input logic last);
    rid = id; rdata = data; rlast = last; rvalid = 1'b1;
    @(negedge clk);
    if (id == 4'd0) chk("beat_ic_data", ic_ret_data, data);
    if (id == 4'd1) chk("beat_d_ok", d_data_ok, last);
    step();
    rvalid = 1'b0; rlast = 1'b0;
  endtask

  int icv0, icl0, dok0;

  initial begin
    // Reset state
    repeat (2) @(negedge clk);
    chk("rst_arvalid", arvalid, 1'b0);
    chk("rst_araddr", araddr, 32'h0);
    chk("rst_arid", arid, 4'h0);
    chk("rst_arlen", arlen, 8'h0);
    chk("rst_arsize", arsize, 3'h0);
    chk("rst_rready", rready, 1'b1);
    step();
    resetn = 1'b1;
    step();

    // Icache line read, then a word read proving ic_out cleared
    icv0 = n_icv; icl0 = n_icl;
    ic_rd_req = 1'b1; ic_rd_type = 3'b100; ic_rd_addr = 32'h1c00_0104;
    wait_acc(1'b0, "line_accept");
    ar_accept("line", 4'd0, 32'h1c00_0100, 8'd3, 3'd2, 0);
    for (int unsigned b = 0; b < 4; b++) beat(4'd0, 32'hA0 + b, b == 3);
    chk("line_beats", n_icv - icv0, 4);
    chk("line_last_pulses", n_icl - icl0, 1);
    ic_rd_req = 1'b1; ic_rd_type = 3'b010; ic_rd_addr = 32'h1c00_0208;
    wait_acc(1'b0, "word_accept_after_line");
    ar_accept("word", 4'd0, 32'h1c00_0208, 8'd0, 3'd2, 0);
    beat(4'd0, 32'h0000_0055, 1'b1);

    // Data byte read
    dok0 = n_dok;
    d_req = 1'b1; d_size = 2'd0; d_addr = 32'h8000_0003;
    wait_acc(1'b1, "byte_accept");
    ar_accept("byte", 4'd1, 32'h8000_0003, 8'd0, 3'd0, 0);
    beat(4'd1, 32'h1234_5678, 1'b1);
    chk("byte_data_ok_pulses", n_dok - dok0, 1);

    // Simultaneous requests: data first, icache right after the handshake
    d_req = 1'b1; d_size = 2'd2; d_addr = 32'h0000_0040;
    ic_rd_req = 1'b1; ic_rd_type = 3'b100; ic_rd_addr = 32'h0000_1010;
    @(negedge clk);
    chk("both_d_addr_ok", d_addr_ok, 1'b1);
    chk("both_ic_rdy", ic_rd_rdy, 1'b0);
    step();
    d_req = 1'b0;
    ar_accept("both_d", 4'd1, 32'h0000_0040, 8'd0, 3'd2, 0);
    @(negedge clk);
    chk("both_ic_rdy_after", ic_rd_rdy, 1'b1);
    step();
    ic_rd_req = 1'b0;
    d_req = 1'b1; d_addr = 32'h0000_0044;
    ar_accept("stall_ic", 4'd0, 32'h0000_1010, 8'd3, 3'd2, 5);
    repeat (2) begin
      @(negedge clk);
      chk("d_busy_no_accept", d_addr_ok, 1'b0);
    end
    step();
    d_req = 1'b0;

    // Interleaved returns
    icv0 = n_icv; icl0 = n_icl; dok0 = n_dok;
    beat(4'd0, 32'hB0, 1'b0);
    beat(4'd0, 32'hB1, 1'b0);
    beat(4'd1, 32'hD0, 1'b1);
    beat(4'd0, 32'hB2, 1'b0);
    beat(4'd0, 32'hB3, 1'b1);
    chk("ilv_ic_beats", n_icv - icv0, 4);
    chk("ilv_ic_last", n_icl - icl0, 1);
    chk("ilv_d_ok", n_dok - dok0, 1);

    // Data blocked: icache served instead
    d_rd_block = 1'b1; d_req = 1'b1; d_addr = 32'h0000_0700;
    ic_rd_req = 1'b1; ic_rd_type = 3'b010; ic_rd_addr = 32'h0000_0300;
    @(negedge clk);
    chk("blk_d_addr_ok", d_addr_ok, 1'b0);
    chk("blk_ic_rdy", ic_rd_rdy, 1'b1);
    step();
    ic_rd_req = 1'b0; d_req = 1'b0; d_rd_block = 1'b0;
    ar_accept("blk_ic", 4'd0, 32'h0000_0300, 8'd0, 3'd2, 0);

    // Beat with unknown rid is dropped
    dok0 = n_dok; icv0 = n_icv;
    beat(4'd5, 32'hDEAD_BEEF, 1'b1);
    chk("stray_d_ok", n_dok - dok0, 0);
    chk("stray_ic", n_icv - icv0, 0);

    // Reset while a data AR is pending and an icache read is outstanding
    d_req = 1'b1; d_size = 2'd1; d_addr = 32'h0000_2002;
    wait_acc(1'b1, "pre_rst_accept");
    @(negedge clk);
    chk("pre_rst_arvalid", arvalid, 1'b1);
    step();
    resetn = 1'b0;
    @(negedge clk);
    chk("mid_rst_arvalid", arvalid, 1'b0);
    chk("mid_rst_araddr", araddr, 32'h0);
    chk("mid_rst_rready", rready, 1'b1);
    step();
    resetn = 1'b1;
    beat(4'd0, 32'h0000_0077, 1'b1);
    ic_rd_req = 1'b1; ic_rd_type = 3'b010; ic_rd_addr = 32'h0000_0500;
    wait_acc(1'b0, "post_rst_ic_accept");
    ar_accept("post_rst_ic", 4'd0, 32'h0000_0500, 8'd0, 3'd2, 0);
    d_req = 1'b1; d_size = 2'd2; d_addr = 32'h0000_0600;
    wait_acc(1'b1, "post_rst_d_accept");
    ar_accept("post_rst_d", 4'd1, 32'h0000_0600, 8'd0, 3'd2, 0);
    beat(4'd1, 32'h0000_0066, 1'b1);
    beat(4'd0, 32'h0000_0055, 1'b1);
    step();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/axi_rd_arbiter.md
# axi_rd_arbiter

Read-side AXI master shared by the instruction cache refill port and the data-side read port. It sits between those two requesters and the AXI AR/R channels, downstream of `cache` and replacing the read half of the bridge. It arbitrates the two into one AR slot, holds the AR payload stable until `arready`, and routes R beats back by `rid`. Each ID may have at most one transaction outstanding; the two IDs may overlap.

## Interface
Parameters:
- `IC_ID`, 4'd0, arid used for icache refills
- `D_ID`, 4'd1, arid used for data reads

Ports:
- `clk`  in  1  single clock
- `resetn`  in  1  asynchronous reset, active-low
- `ic_rd_req`  in  1  icache read request
- `ic_rd_type`  in  3  3'b100 = 16-byte line, 3'b010 = word
- `ic_rd_addr`  in  32  physical address
- `ic_rd_rdy`  out  1  request accepted when high with `ic_rd_req`
- `ic_ret_valid`  out  1  returned beat valid
- `ic_ret_last`  out  1  last beat of burst
- `ic_ret_data`  out  32  beat data
- `d_req`  in  1  data read request
- `d_size`  in  2  0 = byte, 1 = half, 2 = word
- `d_addr`  in  32  physical address
- `d_rd_block`  in  1  write path not drained; hold off data reads
- `d_addr_ok`  out  1  request accepted
- `d_data_ok`  out  1  read data valid
- `d_rdata`  out  32  read data
- `arid`  out  4  AR channel ID
- `araddr`  out  32  AR channel address
- `arlen`  out  8  AR channel burst length
- `arsize`  out  3  AR channel transfer size
- `arburst`  out  2  AR channel burst type
- `arvalid`  out  1  AR channel valid
- `arready`  in  1  AR channel ready
- `rid`  in  4  R channel ID
- `rdata`  in  32  R channel data
- `rresp`  in  2  R channel response; ignored
- `rlast`  in  1  R channel last beat
- `rvalid`  in  1  R channel valid
- `rready`  out  1  R channel ready

## Operation
AR state machine:
- States: `AR_IDLE` (`arvalid`=0) and `AR_SEND` (`arvalid`=1).
- In `AR_IDLE`, select one requester per cycle with fixed priority: data over icache.
- The data request is eligible when `d_req` is high, `d_rd_block` is low and `d_out` is clear.
- The icache request is eligible when `ic_rd_req` is high and `ic_out` is clear.
- `d_addr_ok` = `AR_IDLE` and data eligible.
- `ic_rd_rdy` = `AR_IDLE` and icache eligible and not data eligible.
- On acceptance, register the payload and go to `AR_SEND`.
- Leave `AR_SEND` on `arvalid && arready` and return to `AR_IDLE`. No new request is accepted in that same cycle.

AR payload:
- Icache line: `arid`=`IC_ID`, `araddr`={addr[31:4],4'b0}, `arlen`=3, `arsize`=3'b010.
- Icache word: `arlen`=0, `arsize`=3'b010, address unmodified.
- Data: `arid`=`D_ID`, `araddr`=`d_addr`, `arlen`=0, `arsize`={1'b0,`d_size`}.
- `arburst` is constant 2'b01.

Outstanding flags `ic_out` / `d_out`:
- Set on acceptance of the matching request.
- Cleared on `rvalid && rready && rlast` with the matching `rid`.
- When set and clear happen in the same cycle, the flag ends up set. In practice this cannot occur, because acceptance requires the flag to be clear.

R routing, combinational with zero latency:
- `rready` is constant 1.
- `ic_ret_valid` = `rvalid` and (`rid`==`IC_ID`); `ic_ret_last` = `rlast`; `ic_ret_data` = `rdata`.
- `d_data_ok` = `rvalid` and `rlast` and (`rid`==`D_ID`); `d_rdata` = `rdata`.
- A beat whose `rid` matches neither ID is consumed and dropped, and no flag changes.

## Timing
- Reset values: `arvalid`=0, `arid`=0, `araddr`=0, `arlen`=0, `arsize`=0, flags clear, state `AR_IDLE`.
- `rready`=1 during and after reset.
- A request accepted in cycle N produces `arvalid` high in cycle N+1.
- The AR payload is stable while `arvalid` is high and `arready` is low.
- Best-case issue rate is one request every 2 cycles.
- Requesters hold their request signals until `rdy`/`addr_ok` is seen. The block never accepts without that handshake.
- Beats from the two IDs may interleave arbitrarily; routing is per beat.
- Reset asserted mid-burst aborts all tracking. Beats arriving after reset release with no flag set are still routed on `rid`, and the flags are unaffected.

## Structure
- A shared package holds:
  - ID constants `IC_ID` and `D_ID`.
  - rd_type encodings `RD_LINE`=3'b100 and `RD_WORD`=3'b010.
  - `AXI_BURST_INCR`=2'b01.
  - `LINE_ARLEN`=8'd3.
- One sub-module, `axi_ar_slot`: a single-entry valid/ready holding register for the AR payload (id, addr, len, size). The arbiter logic and R routing stay in the top level.

## Test plan
- Icache line read, `ic_rd_addr`=0x1c000104: AR shows `arid`=0, `araddr`=0x1c000100, `arlen`=3, `arsize`=2. Four beats return 0xA0..0xA3 with `ic_ret_last` only on the 4th; `ic_out` then clears.
- Data byte read, `d_size`=0, `d_addr`=0x80000003: AR shows `arid`=1, `araddr`=0x80000003, `arlen`=0, `arsize`=0. A return of 0x12345678 gives `d_data_ok` for 1 cycle with `d_rdata`=0x12345678.
- Both requests in the same cycle: `d_addr_ok`=1 and `ic_rd_rdy`=0. The data AR issues first. The icache is accepted in the first `AR_IDLE` cycle after the data AR handshake.
- Interleaved returns: icache beats 0,1, then a data beat (`rid`=1), then icache beats 2,3. Each beat is routed correctly, `d_data_ok` pulses once, and `ic_ret_last` pulses once.
- `arready` held low for 5 cycles: `arvalid` and the payload are stable throughout, with no `ic_rd_rdy`/`d_addr_ok`. A second data request while `d_out` is set is not accepted.
- `d_rd_block`=1 with `d_req`=1: `d_addr_ok` stays 0 and the icache request is served instead. Reset mid-burst: `arvalid`=0, both flags clear, and a fresh request is accepted after release.
